// File: rtl/ahb_lite_master_bridge.sv
// AHB-Lite master bridge.
// Turns a valid/ready command stream into single NONSEQ AHB-Lite transfers
// and returns one in-order {rdata, err} response per command through a
// small FIFO. Address and data phases are pipelined. Issue is gated by a
// credit so that every transfer already on the bus has a FIFO slot reserved.
module ahb_lite_master_bridge #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter bit          SEC_TRANS  = 1'b0,
    parameter int unsigned RSP_DEPTH  = 3
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,

    // AHB-Lite manager side
    output logic [ADDR_WIDTH-1:0] HADDR,
    output logic [1:0]            HTRANS,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [3:0]            HPROT,
    output logic                  HMASTLOCK,
    output logic                  HNONSEC,
    output logic [DATA_WIDTH-1:0] HWDATA,
    input  logic [DATA_WIDTH-1:0] HRDATA,
    input  logic                  HREADY,
    input  logic                  HRESP,

    // Command stream
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic                  cmd_write,
    input  logic [2:0]            cmd_size,
    input  logic                  cmd_nonsec,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,

    // Response stream
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (!(DATA_WIDTH == 8   || DATA_WIDTH == 16  || DATA_WIDTH == 32  ||
          DATA_WIDTH == 64  || DATA_WIDTH == 128 || DATA_WIDTH == 256 ||
          DATA_WIDTH == 512 || DATA_WIDTH == 1024)) begin : g_bad_data_width
        $fatal(1, "ahb_lite_master_bridge: illegal DATA_WIDTH %0d", DATA_WIDTH);
    end

    if (RSP_DEPTH < 2) begin : g_bad_rsp_depth
        $fatal(1, "ahb_lite_master_bridge: RSP_DEPTH %0d below minimum of 2", RSP_DEPTH);
    end

    // Pointer width into the FIFO, and a count width that can hold
    // rsp_count + dp_valid (up to RSP_DEPTH + 1) without overflow.
    localparam int unsigned PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int unsigned CW = $clog2(RSP_DEPTH + 1) + 1;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'b00,
        TRANS_NONSEQ = 2'b10
    } htrans_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    // Address-phase register: command presented or waiting on the bus
    logic                  ap_valid;
    logic [ADDR_WIDTH-1:0] ap_addr;
    logic                  ap_write;
    logic [2:0]            ap_size;
    logic                  ap_nonsec;
    logic [DATA_WIDTH-1:0] ap_wdata;

    // Data-phase register: transfer currently in its data phase
    logic                  dp_valid;
    logic                  dp_write;
    logic [DATA_WIDTH-1:0] dp_wdata;

    // Second cycle of a two-cycle ERROR response
    logic                  err2;

    // Response FIFO
    logic [DATA_WIDTH-1:0] fifo_rdata [RSP_DEPTH];
    logic                  fifo_err   [RSP_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         rsp_count;

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    logic                  credit_ok;
    logic                  issue;
    logic                  ap_advance;
    logic                  cmd_fire;
    logic                  dp_done;
    logic                  rsp_push;
    logic                  rsp_pop;
    logic [DATA_WIDTH-1:0] push_rdata;
    logic                  push_err;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Issue/advance decisions; credit uses registered occupancy only, so
    // once NONSEQ is shown it cannot be withdrawn before HREADY.
    always_comb begin
        credit_ok  = (rsp_count + CW'(dp_valid)) < CW'(RSP_DEPTH);
        issue      = ap_valid && credit_ok && !err2;
        ap_advance = issue && HREADY;
        cmd_ready  = !ap_valid || ap_advance;
        cmd_fire   = cmd_valid && cmd_ready;
        dp_done    = dp_valid && HREADY;
        rsp_valid  = (rsp_count != '0);
        rsp_pop    = rsp_valid && rsp_ready;
        rsp_push   = dp_done;
        push_err   = HRESP;
        push_rdata = (!HRESP && !dp_write) ? HRDATA : '0;
    end

    // Bus-facing outputs driven straight from the phase registers
    always_comb begin
        HTRANS    = issue ? TRANS_NONSEQ : TRANS_IDLE;
        HADDR     = ap_addr;
        HWRITE    = ap_write;
        HSIZE     = ap_size;
        HNONSEC   = SEC_TRANS ? ap_nonsec : 1'b0;
        HWDATA    = dp_wdata;
        HBURST    = 3'b000;
        HPROT     = 4'b0011;
        HMASTLOCK = 1'b0;
        rsp_rdata = rsp_valid ? fifo_rdata[rd_ptr] : '0;
        rsp_err   = rsp_valid ? fifo_err[rd_ptr]   : 1'b0;
    end

    // Address-phase register: load on accept, clear when the phase advances
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ap_valid  <= 1'b0;
            ap_addr   <= '0;
            ap_write  <= 1'b0;
            ap_size   <= '0;
            ap_nonsec <= 1'b0;
            ap_wdata  <= '0;
        end else if (cmd_fire) begin
            ap_valid  <= 1'b1;
            ap_addr   <= cmd_addr;
            ap_write  <= cmd_write;
            ap_size   <= cmd_size;
            ap_nonsec <= cmd_nonsec;
            ap_wdata  <= cmd_wdata;
        end else if (ap_advance) begin
            ap_valid  <= 1'b0;
        end
    end

    // Data-phase register: takes over the advancing transfer, drains on HREADY
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_wdata <= '0;
        end else if (ap_advance) begin
            dp_valid <= 1'b1;
            dp_write <= ap_write;
            dp_wdata <= ap_wdata;
        end else if (dp_done) begin
            dp_valid <= 1'b0;
        end
    end

    // ERROR tracking: flag the second cycle so a pending NONSEQ is cancelled
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            err2 <= 1'b0;
        end else if (err2 && HREADY) begin
            err2 <= 1'b0;
        end else if (dp_valid && HRESP && !HREADY) begin
            err2 <= 1'b1;
        end
    end

    // FIFO storage: written on data-phase completion, no reset needed
    always_ff @(posedge HCLK) begin
        if (rsp_push) begin
            fifo_rdata[wr_ptr] <= push_rdata;
            fifo_err[wr_ptr]   <= push_err;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop keep the count
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rsp_count <= '0;
        end else begin
            if (rsp_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rsp_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({rsp_push, rsp_pop})
                2'b10:   rsp_count <= rsp_count + CW'(1);
                2'b01:   rsp_count <= rsp_count - CW'(1);
                default: rsp_count <= rsp_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Protocol assertions
    // ------------------------------------------------------------------
    // The cycle after an ERROR first cycle must complete the ERROR.
    a_err_sequence: assert property (@(posedge HCLK) disable iff (!HRESETn)
        err2 |-> (HREADY && HRESP));

    // Credit reservation makes a push into a full FIFO impossible.
    a_no_overflow: assert property (@(posedge HCLK) disable iff (!HRESETn)
        !(rsp_push && !rsp_pop && (rsp_count == CW'(RSP_DEPTH))));

endmodule

// File: tb/tb_ahb_lite_master_bridge.sv
// Self-checking bench for ahb_lite_master_bridge: a behavioural AHB-Lite
// slave, an in-order response scoreboard fed from a reference memory, and
// directed cycle-level scenarios followed by a randomized run.
`timescale 1ns/1ps
module tb_ahb_lite_master_bridge;

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 3;
    localparam int          MAXC  = 8192;
    localparam logic [31:0] BASE     = 32'h0000_0100;
    localparam logic [31:0] BAD_ADDR = 32'h0000_BAD0;

    logic          HCLK = 1'b0;
    logic          HRESETn;
    logic [AW-1:0] HADDR;
    logic [1:0]    HTRANS;
    logic          HWRITE;
    logic [2:0]    HSIZE;
    logic [2:0]    HBURST;
    logic [3:0]    HPROT;
    logic          HMASTLOCK;
    logic          HNONSEC;
    logic [DW-1:0] HWDATA;
    logic [DW-1:0] HRDATA;
    logic          HREADY;
    logic          HRESP;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic          cmd_write;
    logic [2:0]    cmd_size;
    logic          cmd_nonsec;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;

    ahb_lite_master_bridge #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .SEC_TRANS  (1'b1),
        .RSP_DEPTH  (DEPTH)
    ) dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .HADDR      (HADDR),
        .HTRANS     (HTRANS),
        .HWRITE     (HWRITE),
        .HSIZE      (HSIZE),
        .HBURST     (HBURST),
        .HPROT      (HPROT),
        .HMASTLOCK  (HMASTLOCK),
        .HNONSEC    (HNONSEC),
        .HWDATA     (HWDATA),
        .HRDATA     (HRDATA),
        .HREADY     (HREADY),
        .HRESP      (HRESP),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_write  (cmd_write),
        .cmd_size   (cmd_size),
        .cmd_nonsec (cmd_nonsec),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    always #5 HCLK = ~HCLK;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [2:0]  size;
        logic        nonsec;
        logic [31:0] wdata;
    } cmd_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    cmd_t cmdq[$];
    cmd_t issq[$];
    rsp_t expq[$];
    int   wait_plan[$];
    int   acc_log[$];
    int   iss_log[$];
    int   rsp_log[$];

    logic [31:0] smem    [16];
    logic [31:0] ref_mem [16];

    logic        tr_ns   [MAXC];
    logic        tr_wr   [MAXC];
    logic [31:0] tr_addr [MAXC];
    logic [31:0] tr_wd   [MAXC];

    // Slave model state
    bit          s_busy, s_write, s_err, s_estage, s_first;
    int          s_wait;
    logic [31:0] s_addr, s_wd0;

    // Previous-cycle bus view
    bit          p_ns, p_rdy, p_resp, p_wr;
    logic [31:0] p_addr;

    int outstanding = 0;
    bit accepted    = 0;
    bit rst_req     = 0;
    bit rand_waits  = 0;
    bit rand_rr     = 0;
    bit rand_gap    = 0;
    bit rr_fixed    = 1;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic bit is_bad(input logic [31:0] a);
        return a == BAD_ADDR;
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'(a[5:2]);
    endfunction

    function automatic cmd_t mk_cmd(input logic [31:0] a, input logic w, input logic [2:0] s,
                                    input logic ns, input logic [31:0] d);
        cmd_t c;
        c.addr = a; c.write = w; c.size = s; c.nonsec = ns; c.wdata = d;
        return c;
    endfunction

    // Drive slave response, command stream and rsp_ready for the new cycle.
    task automatic drive_start();
        HRESETn = rst_req;
        HRDATA  = $urandom();
        if (!s_busy) begin
            HREADY = 1'b1; HRESP = 1'b0;
        end else if (s_wait > 0) begin
            HREADY = 1'b0; HRESP = 1'b0;
        end else if (s_err && !s_estage) begin
            HREADY = 1'b0; HRESP = 1'b1;
        end else if (s_err) begin
            HREADY = 1'b1; HRESP = 1'b1;
        end else begin
            HREADY = 1'b1; HRESP = 1'b0;
            if (!s_write) HRDATA = smem[widx(s_addr)];
        end
        if (accepted) begin
            cmd_valid = 1'b0;
            accepted  = 0;
        end
        if (!cmd_valid && cmdq.size() != 0 && (!rand_gap || $urandom_range(0, 2) != 0)) begin
            cmd_valid  = 1'b1;
            cmd_addr   = cmdq[0].addr;
            cmd_write  = cmdq[0].write;
            cmd_size   = cmdq[0].size;
            cmd_nonsec = cmdq[0].nonsec;
            cmd_wdata  = cmdq[0].wdata;
        end
        rsp_ready = rand_rr ? ($urandom_range(0, 3) != 0) : rr_fixed;
    endtask

    // Observe the settled cycle: protocol checks, slave update, scoreboard.
    task automatic monitor();
        cmd_t c;
        rsp_t e;
        bit   ns;
        ns = (HTRANS == 2'b10);
        if (cyc < MAXC) begin
            tr_ns[cyc] = ns; tr_wr[cyc] = HWRITE; tr_addr[cyc] = HADDR; tr_wd[cyc] = HWDATA;
        end
        check_eq("htrans_legal", (HTRANS == 2'b00) || ns, 1);
        if (p_ns && !p_rdy && !p_resp) begin
            check_eq("hold_htrans", HTRANS, 2'b10);
            check_eq("hold_haddr", HADDR, p_addr);
            check_eq("hold_hwrite", HWRITE, p_wr);
        end

        // slave: finish or advance the current data phase
        if (s_busy) begin
            if (s_write) begin
                if (s_first) s_wd0 = HWDATA;
                else check_eq("hwdata_hold", HWDATA, s_wd0);
            end
            s_first = 0;
            if (HREADY) begin
                if (s_write && !s_err) smem[widx(s_addr)] = HWDATA;
                s_busy = 0;
            end else if (s_wait > 0) begin
                s_wait--;
            end else begin
                s_estage = 1;
            end
        end

        // address phase accepted on the bus
        if (ns && HREADY) begin
            iss_log.push_back(cyc);
            check_eq("credit", outstanding < int'(DEPTH), 1);
            outstanding++;
            check_eq("issue_expected", issq.size() != 0, 1);
            if (issq.size() != 0) begin
                c = issq.pop_front();
                check_eq("issue_haddr", HADDR, c.addr);
                check_eq("issue_hwrite", HWRITE, c.write);
                check_eq("issue_hsize", HSIZE, c.size);
                check_eq("issue_hnonsec", HNONSEC, c.nonsec);
            end
            check_eq("const_bus", {HBURST, HPROT, HMASTLOCK}, {3'b000, 4'b0011, 1'b0});
            s_busy = 1; s_addr = HADDR; s_write = HWRITE; s_err = is_bad(HADDR);
            s_estage = 0; s_first = 1;
            if (wait_plan.size() != 0) s_wait = wait_plan.pop_front();
            else s_wait = rand_waits ? $urandom_range(0, 2) : 0;
        end

        // command accepted: reference model produces the expected response
        if (cmd_valid && cmd_ready) begin
            c = cmdq.pop_front();
            acc_log.push_back(cyc);
            issq.push_back(c);
            accepted = 1;
            if (is_bad(c.addr)) begin
                e.rdata = '0; e.err = 1'b1;
            end else if (c.write) begin
                ref_mem[widx(c.addr)] = c.wdata;
                e.rdata = '0; e.err = 1'b0;
            end else begin
                e.rdata = ref_mem[widx(c.addr)]; e.err = 1'b0;
            end
            expq.push_back(e);
        end

        // response handshake
        if (rsp_valid && rsp_ready) begin
            rsp_log.push_back(cyc);
            outstanding--;
            check_eq("rsp_expected", expq.size() != 0, 1);
            if (expq.size() != 0) begin
                e = expq.pop_front();
                check_eq("rsp_rdata", rsp_rdata, e.rdata);
                check_eq("rsp_err", rsp_err, e.err);
            end
        end

        p_ns = ns; p_rdy = HREADY; p_resp = HRESP; p_addr = HADDR; p_wr = HWRITE;
    endtask

    task automatic cycle();
        @(posedge HCLK);
        #1;
        drive_start();
        @(negedge HCLK);
        if (HRESETn) monitor();
        cyc++;
    endtask

    task automatic clear_logs();
        acc_log.delete(); iss_log.delete(); rsp_log.delete();
    endtask

    task automatic run_until(input int n_rsp, input int budget, input string tag);
        int b;
        b = 0;
        while (rsp_log.size() < n_rsp && b < budget) begin
            cycle();
            b++;
        end
        check_eq(tag, rsp_log.size(), n_rsp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_htrans"}, HTRANS, 2'b00);
        check_eq({tag, "_haddr"}, HADDR, 0);
        check_eq({tag, "_hwrite"}, HWRITE, 0);
        check_eq({tag, "_hsize"}, HSIZE, 0);
        check_eq({tag, "_hnonsec"}, HNONSEC, 0);
        check_eq({tag, "_hwdata"}, HWDATA, 0);
        check_eq({tag, "_cmd_ready"}, cmd_ready, 1);
        check_eq({tag, "_rsp_valid"}, rsp_valid, 0);
        check_eq({tag, "_rsp_rdata"}, rsp_rdata, 0);
        check_eq({tag, "_rsp_err"}, rsp_err, 0);
    endtask

    task automatic bench_reset_state();
        cmd_valid = 1'b0; accepted = 0;
        cmdq.delete(); issq.delete(); expq.delete(); wait_plan.delete();
        s_busy = 0; s_wait = 0; outstanding = 0;
        p_ns = 0; p_rdy = 1; p_resp = 0;
        for (int i = 0; i < 16; i++) ref_mem[i] = smem[i];
    endtask

    initial begin
        int a;
        int b;
        logic [31:0] addr;

        HRESETn = 1'b1;
        cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0; cmd_size = '0;
        cmd_nonsec = 1'b0; cmd_wdata = '0;
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0; rsp_ready = 1'b0;
        for (int i = 0; i < 16; i++) smem[i] = 32'h1000_0000 + 32'(i);
        bench_reset_state();
        #2 HRESETn = 1'b0;
        rst_req = 0;
        repeat (3) cycle();
        check_reset_outputs("reset");
        rst_req = 1;
        repeat (2) cycle();

        // single write then read, no wait states
        clear_logs();
        cmdq.push_back(mk_cmd(BASE, 1'b1, 3'd2, 1'b0, 32'hDEAD_BEEF));
        cmdq.push_back(mk_cmd(BASE, 1'b0, 3'd2, 1'b0, 32'h0));
        run_until(2, 50, "t1_rsp_count");
        if (acc_log.size() == 2 && rsp_log.size() == 2) begin
            a = acc_log[0];
            check_eq("t1_ns_c1", tr_ns[a+1], 1);
            check_eq("t1_addr_c1", tr_addr[a+1], BASE);
            check_eq("t1_wr_c1", tr_wr[a+1], 1);
            check_eq("t1_ns_c2", tr_ns[a+2], 1);
            check_eq("t1_wr_c2", tr_wr[a+2], 0);
            check_eq("t1_hwdata_c2", tr_wd[a+2], 32'hDEAD_BEEF);
            check_eq("t1_rsp0_cycle", rsp_log[0], a + 3);
            check_eq("t1_rsp1_cycle", rsp_log[1], a + 4);
        end

        // 8 back-to-back reads
        clear_logs();
        for (int i = 0; i < 8; i++)
            cmdq.push_back(mk_cmd(BASE + 32'(4 * i), 1'b0, 3'd2, 1'(i & 1), 32'h0));
        run_until(8, 60, "t2_rsp_count");
        if (iss_log.size() == 8)
            for (int i = 1; i < 8; i++) check_eq("t2_back_to_back", iss_log[i], iss_log[0] + i);

        // 2 wait states on the 2nd of 3 writes
        clear_logs();
        wait_plan = '{0, 2, 0};
        cmdq.push_back(mk_cmd(BASE + 32'h4, 1'b1, 3'd2, 1'b0, 32'h1111_0001));
        cmdq.push_back(mk_cmd(BASE + 32'h8, 1'b1, 3'd2, 1'b0, 32'h2222_0002));
        cmdq.push_back(mk_cmd(BASE + 32'hC, 1'b1, 3'd2, 1'b0, 32'h3333_0003));
        run_until(3, 60, "t3_rsp_count");
        if (iss_log.size() == 3) begin
            b = iss_log[1];
            check_eq("t3_third_issue", iss_log[2], b + 3);
            for (int k = 1; k <= 3; k++) begin
                check_eq("t3_hold_ns", tr_ns[b+k], 1);
                check_eq("t3_hold_addr", tr_addr[b+k], BASE + 32'hC);
                check_eq("t3_hold_wr", tr_wr[b+k], 1);
                check_eq("t3_hold_hwdata", tr_wd[b+k], 32'h2222_0002);
            end
        end
        clear_logs();
        for (int i = 1; i <= 3; i++)
            cmdq.push_back(mk_cmd(BASE + 32'(4 * i), 1'b0, 3'd2, 1'b0, 32'h0));
        run_until(3, 40, "t3_readback_count");

        // ERROR read with the next command already waiting
        clear_logs();
        cmdq.push_back(mk_cmd(BAD_ADDR, 1'b0, 3'd2, 1'b0, 32'h0));
        cmdq.push_back(mk_cmd(BASE + 32'h14, 1'b0, 3'd2, 1'b0, 32'h0));
        run_until(2, 60, "t4_rsp_count");
        if (iss_log.size() == 2) begin
            a = iss_log[0];
            check_eq("t4_ns_err1", tr_ns[a+1], 1);
            check_eq("t4_addr_err1", tr_addr[a+1], BASE + 32'h14);
            check_eq("t4_idle_err2", tr_ns[a+2], 0);
            check_eq("t4_reissue", iss_log[1], a + 3);
        end

        // response backpressure limits issue to RSP_DEPTH transfers
        clear_logs();
        rr_fixed = 0;
        for (int i = 0; i < 5; i++)
            cmdq.push_back(mk_cmd(BASE + 32'(4 * (i + 8)), 1'b0, 3'd1, 1'b0, 32'h0));
        repeat (12) cycle();
        check_eq("t5_issued_stalled", iss_log.size(), DEPTH);
        check_eq("t5_no_rsp_stalled", rsp_log.size(), 0);
        rr_fixed = 1;
        run_until(5, 60, "t5_rsp_count");

        // asynchronous reset in the middle of a waited write data phase
        clear_logs();
        wait_plan.push_back(3);
        cmdq.push_back(mk_cmd(BASE + 32'h1C, 1'b1, 3'd2, 1'b1, 32'hA5A5_5A5A));
        b = 0;
        while (iss_log.size() == 0 && b < 20) begin
            cycle();
            b++;
        end
        check_eq("t6_issued", iss_log.size(), 1);
        @(posedge HCLK);
        #1;
        drive_start();
        #1;
        check_eq("t6_pre_hwdata", HWDATA, 32'hA5A5_5A5A);
        #1;
        rst_req = 0;
        HRESETn = 1'b0;
        #1;
        check_reset_outputs("t6_reset");
        bench_reset_state();
        repeat (3) cycle();
        rst_req = 1;
        cycle();
        clear_logs();
        cmdq.push_back(mk_cmd(BASE + 32'h1C, 1'b0, 3'd2, 1'b0, 32'h0));
        run_until(1, 20, "t6_after_reset_rsp");
        if (acc_log.size() == 1 && iss_log.size() == 1)
            check_eq("t6_after_reset_issue", iss_log[0], acc_log[0] + 1);

        // randomized traffic: waits, errors, gaps, response backpressure
        clear_logs();
        rand_waits = 1; rand_rr = 1; rand_gap = 1;
        for (int i = 0; i < 300; i++) begin
            addr = ($urandom_range(0, 9) == 0) ? BAD_ADDR : BASE + ($urandom_range(0, 15) << 2);
            cmdq.push_back(mk_cmd(addr, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 2)),
                                  1'($urandom_range(0, 1)), $urandom()));
        end
        run_until(300, 6000, "t7_rsp_count");
        rand_waits = 0; rand_rr = 0; rand_gap = 0;
        repeat (4) cycle();
        check_eq("final_expq_empty", expq.size(), 0);
        check_eq("final_cmdq_empty", cmdq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
